carry_skip_subtractor_seq: RTL and testbench
============================================

Name: carry_skip_subtractor_seq

Overview:
Iterative, multi-cycle carry-skip subtractor. It computes diff = a - b - bin, resolving one BLOCK_SIZE slice per clock and skipping borrow ripple across any block whose bits all propagate. It is the subtract-direction counterpart to the combinational carry_skip_adder in the arithmetic benchmarking set, and uses valid/ready handshakes for pipeline integration.

Parameters:
N, 8, operand/result width in bits; N >= 1.
BLOCK_SIZE, 4, bits resolved per cycle; N % BLOCK_SIZE == 0, else elaboration error.
NUM_BLOCKS, N/BLOCK_SIZE, derived localparam, not overridable.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands present.
in_ready  output  1  block can accept operands.
a  input  N  minuend (unsigned).
b  input  N  subtrahend (unsigned).
bin  input  1  borrow in.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts result.
diff  output  N  (a - b - bin) mod 2^N.
bout  output  1  final borrow; 1 iff a < b + bin.

Behaviour:
- Reset: one clock (clk); rst_n is asynchronous, active-low.
  - While rst_n=0: state=IDLE, in_ready=0, out_valid=0, diff=0, bout=0, block index=0, internal regs cleared.
  - Deassertion: in_ready=1 from the first clk edge after rst_n rises.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - in_valid&&in_ready at an edge latches a, b, bin, clears idx, and moves to CALC.
- CALC:
  - in_ready=0; in_valid is ignored.
  - At each edge, block idx (bits idx*BLOCK_SIZE +: BLOCK_SIZE) is computed from the registered borrow:
    - d_i = a_i ^ b_i ^ br_i.
    - Ripple borrow = (~a_i & b_i) | (~(a_i ^ b_i) & br_i).
    - Skip: when all bits in the block have a_i == b_i, block borrow-out = block borrow-in (mux bypass).
  - diff slice is written; idx increments.
  - After the edge processing idx==NUM_BLOCKS-1, go to DONE with out_valid=1 and bout=final borrow.
- Latency: out_valid rises exactly NUM_BLOCKS edges after the accept edge.
- DONE:
  - out_valid=1; diff and bout held stable.
  - out_valid&&out_ready at an edge returns to IDLE (out_valid=0, in_ready=1).
  - No same-cycle re-accept; throughput is one op per NUM_BLOCKS+2 cycles minimum.
- diff/bout hold their last result in IDLE. They are overwritten slice-wise during CALC and are valid only while out_valid=1.
- Reset mid-CALC or mid-DONE aborts immediately; the result is discarded.
- N=BLOCK_SIZE=1: NUM_BLOCKS=1, latency 1.

Optional Feature:
Macro CSK_SKIP_COUNT_EN.
- Defined: adds output skip_count, width $clog2(NUM_BLOCKS+1).
  - Cleared on accept; +1 per CALC block taking the skip path.
  - Held through DONE/IDLE; reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package carry_skip_pkg:
  - state enum {IDLE, CALC, DONE}.
  - function num_blocks(N, BLOCK_SIZE).
  - skip-count width function.
- Sub-module csk_sub_block (combinational, BLOCK_SIZE param).
  - Inputs: a, b, bin.
  - Outputs: diff, bout, skip.
  - Instantiated once and muxed by idx.

Test Plan:
- Reset: hold rst_n=0 5 cycles, assert mid-cycle -> out_valid=0, diff=0, bout=0, in_ready=0; in_ready=1 one edge after release.
- N=8,B=4: a=8'h05,b=8'h03,bin=0 -> out_valid exactly 2 edges after accept, diff=8'h02, bout=0.
- a=8'h00,b=8'h01,bin=0 -> diff=8'hFF, bout=1; a=8'h3C,b=8'h3C,bin=1 -> diff=8'hFF, bout=1, skip_count=2 (CSK_SKIP_COUNT_EN).
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> diff/bout stable, in_ready=0, new operands not taken; out_ready=1 -> IDLE next edge.
- Reset mid-CALC (after 1 of 2 blocks) -> IDLE, out_valid=0, no result emitted; next op a=8'hA0,b=8'h0F,bin=0 -> diff=8'h91, bout=0.
- N=1,B=1 exhaustive 8 combos of (a,b,bin) -> match 1-bit (a-b-bin) mod 2 and borrow, latency 1 each.

Source files
------------

// File: rtl/carry_skip_pkg.sv
// Shared types and elaboration helpers for the iterative carry-skip subtractor.
package carry_skip_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int unsigned num_blocks(input int unsigned n, input int unsigned bs);
        return n / bs;
    endfunction

    function automatic int unsigned skip_count_width(input int unsigned nb);
        return $clog2(nb + 1);
    endfunction

    // Block index register needs at least one bit even when there is a single block.
    function automatic int unsigned idx_width(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/csk_sub_block.sv
// One combinational carry-skip subtract slice: ripple borrow with an all-propagate bypass.
module csk_sub_block #(
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic [BLOCK_SIZE-1:0] a,
    input  logic [BLOCK_SIZE-1:0] b,
    input  logic                  bin,
    output logic [BLOCK_SIZE-1:0] diff,
    output logic                  bout,
    output logic                  skip
);

    logic [BLOCK_SIZE:0]   br;
    logic [BLOCK_SIZE-1:0] p;

    assign p = ~(a ^ b);

    always_comb begin
        br    = '0;
        diff  = '0;
        br[0] = bin;
        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
            diff[i]  = a[i] ^ b[i] ^ br[i];
            br[i+1]  = (~a[i] & b[i]) | (p[i] & br[i]);
        end
    end

    assign skip = &p;
    assign bout = skip ? bin : br[BLOCK_SIZE];

endmodule

// File: rtl/carry_skip_subtractor_seq.sv
// Multi-cycle carry-skip subtractor, one block per clock, valid/ready on both sides.
// Optional CSK_SKIP_COUNT_EN adds a skip_count output counting bypassed blocks.
module carry_skip_subtractor_seq
    import carry_skip_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef CSK_SKIP_COUNT_EN
    ,
    output logic [skip_count_width(N/BLOCK_SIZE)-1:0] skip_count
`endif
);

    localparam int unsigned NUM_BLOCKS = num_blocks(N, BLOCK_SIZE);
    localparam int unsigned IDXW       = idx_width(NUM_BLOCKS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BLOCKS - 1);

    if (N < 1 || BLOCK_SIZE < 1 || (N % BLOCK_SIZE) != 0) begin : g_bad_params
        $error("carry_skip_subtractor_seq: N must be a positive multiple of BLOCK_SIZE");
    end

    state_t                state, state_nx;
    logic [N-1:0]          a_q, b_q;
    logic                  br_q;
    logic [IDXW-1:0]       idx;
    logic [BLOCK_SIZE-1:0] a_blk [NUM_BLOCKS];
    logic [BLOCK_SIZE-1:0] b_blk [NUM_BLOCKS];
    logic [BLOCK_SIZE-1:0] blk_a, blk_b, blk_diff;
    logic                  blk_bout, blk_skip;
    logic                  accept, last;

    for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_slice
        assign a_blk[g] = a_q[g*BLOCK_SIZE +: BLOCK_SIZE];
        assign b_blk[g] = b_q[g*BLOCK_SIZE +: BLOCK_SIZE];
    end

    assign blk_a = a_blk[idx];
    assign blk_b = b_blk[idx];

    csk_sub_block #(
        .BLOCK_SIZE(BLOCK_SIZE)
    ) u_blk (
        .a   (blk_a),
        .b   (blk_b),
        .bin (br_q),
        .diff(blk_diff),
        .bout(blk_bout),
        .skip(blk_skip)
    );

    assign accept = in_valid && in_ready;
    assign last   = (idx == LAST_IDX);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    if (last) state_nx = DONE;
            DONE:    if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so both stay low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            br_q      <= 1'b0;
            idx       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q  <= a;
                        b_q  <= b;
                        br_q <= bin;
                        idx  <= '0;
                    end
                end
                CALC: begin
                    br_q <= blk_bout;
                    idx  <= last ? '0 : idx + 1'b1;
                    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
                        if (idx == IDXW'(i)) diff[i*BLOCK_SIZE +: BLOCK_SIZE] <= blk_diff;
                    end
                    if (last) bout <= blk_bout;
                end
                default: ;
            endcase
        end
    end

`ifdef CSK_SKIP_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_count <= '0;
        end else if (state == IDLE && accept) begin
            skip_count <= '0;
        end else if (state == CALC && blk_skip) begin
            skip_count <= skip_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_carry_skip_subtractor_seq.sv
// Directed self-checking bench for carry_skip_subtractor_seq at N=8/B=4 and N=1/B=1.
module tb_carry_skip_subtractor_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, bin8 = 1'b0, bo8;
    logic [7:0] a8 = '0, b8 = '0, d8;
    logic [1:0] sc8;

    logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b0, bin1 = 1'b0, bo1;
    logic [0:0] a1 = '0, b1 = '0, d1;
    logic [0:0] sc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    carry_skip_subtractor_seq #(.N(8), .BLOCK_SIZE(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(ov8), .out_ready(or8),
        .diff(d8), .bout(bo8)
`ifdef CSK_SKIP_COUNT_EN
        , .skip_count(sc8)
`endif
    );

    carry_skip_subtractor_seq #(.N(1), .BLOCK_SIZE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .bin(bin1), .out_valid(ov1), .out_ready(or1),
        .diff(d1), .bout(bo1)
`ifdef CSK_SKIP_COUNT_EN
        , .skip_count(sc1)
`endif
    );

`ifndef CSK_SKIP_COUNT_EN
    assign sc8 = '0;
    assign sc1 = '0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        int         sk;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic bn);
        int w = 0;
        while (!ir8 && w < 20) begin @(posedge clk); #1; w++; end
        chk("in_ready_wait8", 32'(ir8), 32'd1);
        a8 = av; b8 = bv; bin8 = bn; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic wait_out8(output int lat);
        lat = 0;
        while (!ov8 && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic drain8();
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("ov_after_drain8", 32'(ov8), 32'd0);
        chk("ir_after_drain8", 32'(ir8), 32'd1);
    endtask

    task automatic run1(input logic av, input logic bv, input logic bn);
        int w = 0;
        int lat = 0;
        logic [1:0] want_bo;
        while (!ir1 && w < 20) begin @(posedge clk); #1; w++; end
        chk("in_ready_wait1", 32'(ir1), 32'd1);
        a1 = av; b1 = bv; bin1 = bn; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        while (!ov1 && lat < 20) begin @(posedge clk); #1; lat++; end
        want_bo = ({1'b0, av} < ({1'b0, bv} + {1'b0, bn})) ? 2'd1 : 2'd0;
        chk("lat1", 32'(lat), 32'd1);
        chk("diff1", 32'(d1), 32'(av ^ bv ^ bn));
        chk("bout1", 32'(bo1), 32'(want_bo));
`ifdef CSK_SKIP_COUNT_EN
        chk("skip1", 32'(sc1), (av == bv) ? 32'd1 : 32'd0);
`endif
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        chk("ov_after_drain1", 32'(ov1), 32'd0);
    endtask

    initial begin
        int lat;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1};
        vecs[2] = '{8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 2};
        vecs[3] = '{8'hA0, 8'h0F, 1'b0, 8'h91, 1'b0, 0};
        vecs[4] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 0};
        vecs[5] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 0};
        vecs[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 0};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 0};
        vecs[8] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0};
        vecs[9] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 2};

        // Reset: held 5 cycles, sampled mid-cycle.
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_diff", 32'(d8), 32'd0);
        chk("rst_bout", 32'(bo8), 32'd0);
        chk("rst_in_ready", 32'(ir8), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", 32'(ir8), 32'd0);
        @(posedge clk); #1;
        chk("in_ready_after_release8", 32'(ir8), 32'd1);
        chk("in_ready_after_release1", 32'(ir1), 32'd1);

        for (int i = 0; i < 10; i++) begin
            start8(vecs[i].a, vecs[i].b, vecs[i].bin);
            chk("ir_low_in_calc", 32'(ir8), 32'd0);
            wait_out8(lat);
            chk("lat8", 32'(lat), 32'd2);
            chk("diff8", 32'(d8), 32'(vecs[i].d));
            chk("bout8", 32'(bo8), 32'(vecs[i].bo));
`ifdef CSK_SKIP_COUNT_EN
            chk("skip8", 32'(sc8), 32'(vecs[i].sk));
`endif
            drain8();
        end

        // Backpressure in DONE with new operands presented.
        start8(8'h05, 8'h03, 1'b0);
        wait_out8(lat);
        chk("bp_lat", 32'(lat), 32'd2);
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_diff", 32'(d8), 32'h02);
            chk("bp_bout", 32'(bo8), 32'd0);
            chk("bp_in_ready", 32'(ir8), 32'd0);
            chk("bp_out_valid", 32'(ov8), 32'd1);
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        iv8 = 1'b0;
        chk("bp_release_ov", 32'(ov8), 32'd0);
        chk("bp_release_ir", 32'(ir8), 32'd1);
        chk("bp_hold_diff", 32'(d8), 32'h02);
        @(posedge clk); #1;
        chk("bp_not_taken_ov", 32'(ov8), 32'd0);
        chk("bp_not_taken_ir", 32'(ir8), 32'd1);

        // Reset after the first of two blocks.
        start8(8'h12, 8'h34, 1'b0);
        @(posedge clk); #1;
        chk("midcalc_ov", 32'(ov8), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_ov", 32'(ov8), 32'd0);
        chk("abort_ir", 32'(ir8), 32'd0);
        chk("abort_diff", 32'(d8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_result", 32'(ov8), 32'd0);
        end
        start8(8'hA0, 8'h0F, 1'b0);
        wait_out8(lat);
        chk("post_abort_lat", 32'(lat), 32'd2);
        chk("post_abort_diff", 32'(d8), 32'h91);
        chk("post_abort_bout", 32'(bo8), 32'd0);
        drain8();

        // N=1, BLOCK_SIZE=1 exhaustive.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run1(v[2], v[1], v[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
